// File: rtl/sobel_frame_ctrl_if.sv
// Video stream bundle between the pixel source and sobel_frame_ctrl:
// raw dv/hs/vs in, aligned coordinates, strobes and geometry status out.
interface sobel_frame_ctrl_if #(
  parameter int MAX_W = 2048,
  parameter int MAX_H = 2048
);
  localparam int COL_W = $clog2(MAX_W);
  localparam int ROW_W = $clog2(MAX_H);

  // Handshake: no backpressure. dv_i qualifies the input pixel on every clock
  // edge it is high; dv_o qualifies col_o/row_o the same way one cycle later.
  logic             dv_i;
  logic             hs_i;
  logic             vs_i;
  logic             dv_o;
  logic [COL_W-1:0] col_o;
  logic [ROW_W-1:0] row_o;
  logic             win_valid_o;
  logic             line_end_o;
  logic             frame_start_o;
  logic             buf_clr_o;
  logic [COL_W:0]   line_width_o;
  logic             err_o;

  modport master (
    output dv_i, hs_i, vs_i,
    input  dv_o, col_o, row_o, win_valid_o, line_end_o, frame_start_o,
           buf_clr_o, line_width_o, err_o
  );

  modport slave (
    input  dv_i, hs_i, vs_i,
    output dv_o, col_o, row_o, win_valid_o, line_end_o, frame_start_o,
           buf_clr_o, line_width_o, err_o
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Sequencing controller for the Sobel pipeline: pixel coordinates, line/frame
// strobes, 3x3 window qualifier and stream geometry checking.
module sobel_frame_ctrl #(
  parameter int MAX_W = 2048,
  parameter int MAX_H = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_frame_ctrl_if.slave     stream,
  output logic [2:0]            dbg_o
);
  localparam int COL_W = $clog2(MAX_W);
  localparam int ROW_W = $clog2(MAX_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAX_H - 1);

  typedef enum logic [1:0] {WAIT_VS, VBLANK, HBLANK, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic             vs_q, hs_q;
  logic             dv_q, dv_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             win_q, win_d;
  logic             le_q, le_d;
  logic             fs_q, fs_d;
  logic [COL_W:0]   width_q, width_d;
  logic [COL_W:0]   ref_q, ref_d;
  logic             err_q, err_d;
  logic             vs_rise;
  logic [COL_W:0]   pix_cnt;

  assign vs_rise = stream.vs_i & ~vs_q;
  assign pix_cnt = {1'b0, col_q} + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_VS;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (vs_rise) begin
      state_d = VBLANK;
    end else begin
      case (state_q)
        WAIT_VS: if (stream.vs_i)  state_d = VBLANK;
        VBLANK:  if (!stream.vs_i) state_d = HBLANK;
        HBLANK:  if (stream.dv_i)  state_d = ACTIVE;
        ACTIVE:  if (!stream.dv_i) state_d = HBLANK;
        default: state_d = WAIT_VS;
      endcase
    end
  end

  always_comb begin
    dv_d    = 1'b0;
    col_d   = col_q;
    row_d   = row_q;
    le_d    = 1'b0;
    fs_d    = 1'b0;
    width_d = width_q;
    ref_d   = ref_q;
    err_d   = err_q;
    if (vs_rise) begin
      // A line cut short by vsync is abandoned without a width check.
      fs_d  = 1'b1;
      err_d = 1'b0;
      col_d = '0;
      row_d = '0;
    end else begin
      case (state_q)
        VBLANK: if (!stream.vs_i) begin
          col_d = '0;
          row_d = '0;
          ref_d = '0;
          if (stream.dv_i) err_d = 1'b1;
        end
        HBLANK: if (stream.dv_i) begin
          dv_d  = 1'b1;
          col_d = '0;
        end
        ACTIVE: begin
          if (stream.dv_i) begin
            dv_d = 1'b1;
            if (col_q == COL_MAX) err_d = 1'b1;
            else                  col_d = col_q + 1'b1;
          end else begin
            le_d    = 1'b1;
            col_d   = '0;
            width_d = pix_cnt;
            // Reference width 0 means no line has completed yet this frame.
            if (ref_q == '0)           ref_d = pix_cnt;
            else if (pix_cnt != ref_q) err_d = 1'b1;
            if (row_q == ROW_MAX) err_d = 1'b1;
            else                  row_d = row_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    win_d = dv_d && (col_d > COL_W'(1)) && (row_d > ROW_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      dv_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= 1'b0;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
      width_q <= '0;
      ref_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      vs_q    <= stream.vs_i;
      hs_q    <= stream.hs_i;
      dv_q    <= dv_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
      width_q <= width_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
    end
  end

  assign stream.dv_o          = dv_q;
  assign stream.col_o         = col_q;
  assign stream.row_o         = row_q;
  assign stream.win_valid_o   = win_q;
  assign stream.line_end_o    = le_q;
  assign stream.frame_start_o = fs_q;
  assign stream.buf_clr_o     = fs_q;
  assign stream.line_width_o  = width_q;
  assign stream.err_o         = err_q;
  assign dbg_o                = {hs_q, state_q};
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: directed frames checked every cycle against a
// pixel-counting model, plus hand-computed literal checkpoints.
module tb_sobel_frame_ctrl;
  localparam int MAX_W = 8;
  localparam int MAX_H = 4;

  localparam int M_WAIT = 0;
  localparam int M_VB   = 1;
  localparam int M_HB   = 2;
  localparam int M_LINE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int le_cnt = 0;
  int win_cnt = 0;
  int fs_cnt = 0;

  // Model: raw pixel/line counts, clamped only when turned into coordinates.
  int m_mode, m_px, m_lines, m_ref, m_width;
  bit m_err, m_vs_prev, e_dv, e_le, e_fs;

  sobel_frame_ctrl_if #(.MAX_W(MAX_W), .MAX_H(MAX_H)) vif();

  sobel_frame_ctrl #(.MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
    .clk    (clk),
    .rst    (rst),
    .stream (vif),
    .dbg_o  (dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_WAIT; m_px = 0; m_lines = 0; m_ref = 0; m_width = 0;
    m_err = 0; m_vs_prev = 0; e_dv = 0; e_le = 0; e_fs = 0;
  endtask

  task automatic model_step(input bit dv, input bit vs);
    int w;
    e_dv = 0; e_le = 0; e_fs = 0;
    if (vs && !m_vs_prev) begin
      m_mode = M_VB; e_fs = 1; m_err = 0; m_px = 0; m_lines = 0;
    end else begin
      case (m_mode)
        M_WAIT: if (vs) m_mode = M_VB;
        M_VB: if (!vs) begin
          m_mode = M_HB; m_px = 0; m_lines = 0; m_ref = 0;
          if (dv) m_err = 1;
        end
        M_HB: if (dv) begin
          m_mode = M_LINE; m_px = 1; e_dv = 1;
        end
        default: begin
          if (dv) begin
            m_px++; e_dv = 1;
            if (m_px > MAX_W) m_err = 1;
          end else begin
            e_le = 1;
            w = (m_px > MAX_W) ? MAX_W : m_px;
            m_width = w;
            if (m_ref == 0) m_ref = w;
            else if (w != m_ref) m_err = 1;
            if (m_lines >= MAX_H - 1) m_err = 1;
            m_lines++;
            m_px = 0;
            m_mode = M_HB;
          end
        end
      endcase
    end
    m_vs_prev = vs;
  endtask

  function automatic int exp_col();
    if (m_px == 0) return 0;
    return (m_px - 1 > MAX_W - 1) ? MAX_W - 1 : m_px - 1;
  endfunction

  function automatic int exp_row();
    return (m_lines > MAX_H - 1) ? MAX_H - 1 : m_lines;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dv_o", int'(vif.dv_o), int'(e_dv));
      chk("col_o", int'(vif.col_o), exp_col());
      chk("row_o", int'(vif.row_o), exp_row());
      chk("win_valid_o", int'(vif.win_valid_o),
          int'(e_dv && exp_col() >= 2 && exp_row() >= 2));
      chk("line_end_o", int'(vif.line_end_o), int'(e_le));
      chk("frame_start_o", int'(vif.frame_start_o), int'(e_fs));
      chk("buf_clr_o", int'(vif.buf_clr_o), int'(e_fs));
      chk("line_width_o", int'(vif.line_width_o), m_width);
      chk("err_o", int'(vif.err_o), int'(m_err));
      if (vif.line_end_o) le_cnt++;
      if (vif.win_valid_o) win_cnt++;
      if (vif.frame_start_o) fs_cnt++;
    end
  end

  task automatic cyc(input bit dv, input bit vs);
    vif.dv_i = dv;
    vif.vs_i = vs;
    vif.hs_i = ~dv;
    @(posedge clk);
    model_step(dv, vs);
    @(negedge clk);
  endtask

  task automatic frame_hdr();
    cyc(0, 1);
    cyc(0, 1);
    cyc(0, 0);
  endtask

  task automatic line(input int n, input int gap);
    for (int i = 0; i < n; i++) cyc(1, 0);
    for (int i = 0; i < gap; i++) cyc(0, 0);
  endtask

  task automatic clr_cnt();
    le_cnt = 0; win_cnt = 0; fs_cnt = 0;
  endtask

  initial begin
    vif.dv_i = 1'b0;
    vif.vs_i = 1'b0;
    vif.hs_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset dv_o", int'(vif.dv_o), 0);
    chk("reset line_width_o", int'(vif.line_width_o), 0);
    chk("reset state", int'(dbg[1:0]), 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // dv without vsync is ignored
    for (int i = 0; i < 5; i++) cyc(1, 0);
    chk("no-vs dv_o", int'(vif.dv_o), 0);
    chk("no-vs col_o", int'(vif.col_o), 0);

    // Frame A: three 4-pixel lines with 2-cycle gaps
    clr_cnt();
    frame_hdr();
    for (int l = 0; l < 3; l++) line(4, 2);
    chk("A line_end count", le_cnt, 3);
    chk("A win count", win_cnt, 2);
    chk("A frame_start count", fs_cnt, 1);
    chk("A line_width", int'(vif.line_width_o), 4);
    chk("A err", int'(vif.err_o), 0);
    chk("A row after", int'(vif.row_o), 3);

    // Frame B: widths 4,4,5 back-to-back
    frame_hdr();
    line(4, 1);
    line(4, 1);
    chk("B err before", int'(vif.err_o), 0);
    line(5, 1);
    chk("B err after", int'(vif.err_o), 1);
    chk("B line_width", int'(vif.line_width_o), 5);
    cyc(0, 0);
    chk("B err sticky", int'(vif.err_o), 1);
    cyc(0, 1);
    chk("B err cleared", int'(vif.err_o), 0);
    cyc(0, 0);

    // vsync rising mid-line at col 2, then vs falling with dv high
    frame_hdr();
    line(3, 0);
    chk("cut col before", int'(vif.col_o), 2);
    cyc(1, 1);
    chk("cut line_end", int'(vif.line_end_o), 0);
    chk("cut frame_start", int'(vif.frame_start_o), 1);
    chk("cut buf_clr", int'(vif.buf_clr_o), 1);
    chk("cut col", int'(vif.col_o), 0);
    chk("cut row", int'(vif.row_o), 0);
    cyc(1, 0);
    chk("vs-fall dv dropped", int'(vif.dv_o), 0);
    chk("vs-fall err", int'(vif.err_o), 1);
    cyc(0, 0);

    // Column overflow: 10 pixels with MAX_W=8
    frame_hdr();
    line(10, 0);
    chk("ovf col", int'(vif.col_o), 7);
    chk("ovf err", int'(vif.err_o), 1);
    cyc(0, 0);
    chk("ovf width", int'(vif.line_width_o), 8);

    // Row overflow: five 2-pixel lines with MAX_H=4
    frame_hdr();
    for (int l = 0; l < 3; l++) line(2, 1);
    chk("rowsat err early", int'(vif.err_o), 0);
    line(2, 1);
    chk("rowsat row", int'(vif.row_o), 3);
    chk("rowsat err", int'(vif.err_o), 1);
    line(2, 1);

    // Asynchronous reset mid-line
    frame_hdr();
    line(2, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst dv_o", int'(vif.dv_o), 0);
    chk("rst col_o", int'(vif.col_o), 1 - 1);
    chk("rst line_width", int'(vif.line_width_o), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0);
    chk("post-rst dv_o", int'(vif.dv_o), 0);
    frame_hdr();
    line(3, 2);
    chk("resync width", int'(vif.line_width_o), 3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
